// File: rtl/pipe_pkg.sv
// pipe_pkg: shared helpers and stage control record for pipe_reg_chain
//   occ_width(depth)  width of an occupancy counter able to hold 0..depth
//   PIPE_DEPTH_MAX    largest supported stage count
//   stage_ctrl_t      per-stage control bits; parity bit exists only with PIPE_REG_CHAIN_PARITY_EN
package pipe_pkg;
  localparam int PIPE_DEPTH_MAX = 16;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic valid;
`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic parity;
`endif
  } stage_ctrl_t;
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one elastic register stage (valid + data) with load/clear/hold
//   clk, rst (async, active-low), en (freeze when 0), clr (sync flush)
//   load/load_data   write a new word into this stage
//   down_free        the next stage (or the consumer) can take this word now
//   valid/data       registered contents; pop = word leaves this cycle; free = stage can accept
//   load_par/parity  stored even-parity bit, only with PIPE_REG_CHAIN_PARITY_EN
module pipe_stage import pipe_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`ifdef PIPE_REG_CHAIN_PARITY_EN
  input  logic             load_par,
  output logic             parity,
`endif
  input  logic             down_free,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             pop,
  output logic             free
);
  stage_ctrl_t ctrl;
  assign valid = ctrl.valid;
`ifdef PIPE_REG_CHAIN_PARITY_EN
  assign parity = ctrl.parity;
`endif
  assign pop  = ctrl.valid & down_free;
  // a full stage is still free when its word leaves in the same cycle
  assign free = !ctrl.valid | pop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ctrl <= '0;
      data <= RST_VAL;
    end else if (clr) begin
      ctrl <= '0;
      data <= RST_VAL;
    end else if (en && load) begin
      ctrl.valid <= 1'b1;
`ifdef PIPE_REG_CHAIN_PARITY_EN
      ctrl.parity <= load_par;
`endif
      data <= load_data;
    end else if (en && pop) begin
      ctrl.valid <= 1'b0;
    end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready backpressure
//   clk, rst (async, active-low), en (0 freezes everything), clr (sync flush of all stages)
//   in_valid/in_data/in_ready     upstream handshake into stage 0
//   out_valid/out_data/out_ready  downstream handshake from stage DEPTH-1
//   occupancy                     registered count of valid stages
//   parity_err                    stored parity mismatch at the output (PIPE_REG_CHAIN_PARITY_EN only)
module pipe_reg_chain import pipe_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
`ifdef PIPE_REG_CHAIN_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [occ_width(DEPTH)-1:0]   occupancy
);
  localparam int OW = occ_width(DEPTH);
  logic live, push;
  logic [DEPTH-1:0] nxt_v;
  if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH out of range");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_reg_chain: WIDTH must be at least 1");
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic ld, dn_free, valid, pop, free;
    logic [WIDTH-1:0] ld_data, data;
`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic ld_par, par;
`endif
    if (g == 0) begin : g_head
      assign ld      = push;
      assign ld_data = in_data;
`ifdef PIPE_REG_CHAIN_PARITY_EN
      assign ld_par  = ^in_data;
`endif
    end else begin : g_body
      assign ld      = g_stage[g-1].pop;
      assign ld_data = g_stage[g-1].data;
`ifdef PIPE_REG_CHAIN_PARITY_EN
      assign ld_par  = g_stage[g-1].par;
`endif
    end
    // the ready chain runs combinationally from out_ready back to stage 0
    if (g == DEPTH - 1) begin : g_tail
      assign dn_free = out_ready & en;
    end else begin : g_link
      assign dn_free = g_stage[g+1].free;
    end
    assign nxt_v[g] = !clr & (en ? ld | (valid & !pop) : valid);
    pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk(clk),
      .rst(rst),
      .en(en),
      .clr(clr),
      .load(ld),
      .load_data(ld_data),
`ifdef PIPE_REG_CHAIN_PARITY_EN
      .load_par(ld_par),
      .parity(par),
`endif
      .down_free(dn_free),
      .valid(valid),
      .data(data),
      .pop(pop),
      .free(free)
    );
  end
  // live holds in_ready low from reset assertion until the first edge after release
  always_ff @(posedge clk or negedge rst)
    if (!rst) live <= 1'b0;
    else live <= 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) occupancy <= '0;
    else occupancy <= OW'($countones(nxt_v));
  assign in_ready  = live & en & !clr & g_stage[0].free;
  assign push      = in_valid & in_ready;
  assign out_valid = g_stage[DEPTH-1].valid & en;
  assign out_data  = g_stage[DEPTH-1].data;
`ifdef PIPE_REG_CHAIN_PARITY_EN
  assign parity_err = out_valid & ((^out_data) != g_stage[DEPTH-1].par);
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: scoreboard bench for pipe_reg_chain (directed scenarios plus random traffic)
`timescale 1ns/1ps
module tb_pipe_reg_chain;
  localparam int W = 8;
  localparam int D = 3;
  localparam int OW = $clog2(D + 1);
  logic clk = 0, rst = 0, en = 0, clr = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [OW-1:0] occupancy;
`ifdef PIPE_REG_CHAIN_PARITY_EN
  logic parity_err;
  logic pbad;
`endif
  int checks = 0, errors = 0, n_out = 0;
  logic [W-1:0] exp_q[$];
  logic up = 0;
  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RST_VAL('0)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clr(clr),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
`ifdef PIPE_REG_CHAIN_PARITY_EN
    .parity_err(parity_err),
`endif
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  // the pipeline accepts input from the first clock edge after reset release
  always @(posedge clk or negedge rst)
    if (!rst) up <= 1'b0;
    else up <= 1'b1;
  // monitor: checks every cycle against the word queue held by the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_in_ready", in_ready, 0);
      exp_q.delete();
    end else begin
      chk("occupancy", occupancy, exp_q.size());
      chk("in_ready", in_ready, up && en && !clr && (exp_q.size() < D || out_ready));
      if (!en || exp_q.size() == 0) chk("out_valid_low", out_valid, 0);
      else if (exp_q.size() == D) chk("out_valid_full", out_valid, 1);
`ifdef PIPE_REG_CHAIN_PARITY_EN
      chk("parity_err_clean", parity_err, 0);
`endif
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h, expected no valid output", out_data);
        end else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (clr) exp_q.delete();
    end
  end
  task automatic step(input logic v, input logic [W-1:0] dat, input logic ordy, output logic acc);
    in_valid = v;
    in_data = dat;
    out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    if (acc) exp_q.push_back(dat);
    #1;
  endtask
  initial begin
    logic acc;
    int n0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    en = 1;
    // reset mid-stream
    step(0, 0, 0, acc);
    step(1, 8'h11, 0, acc);
    chk("rst_push_11", acc, 1);
    step(1, 8'h22, 0, acc);
    chk("rst_push_22", acc, 1);
    in_valid = 0;
    rst = 0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_occupancy", occupancy, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_out_data", out_data, 0);
    exp_q.delete();
    #1;
    rst = 1;
    #1;
    chk("release_in_ready", in_ready, 0);
    chk("release_out_data", out_data, 0);
    step(0, 0, 0, acc);
    // streaming with latency and throughput
    n0 = n_out;
    for (int i = 1; i <= 8; i++) begin
      step(1, W'(i), 1, acc);
      chk("stream_accept", acc, 1);
      #3;
      chk("stream_out_valid", out_valid, i >= D);
      if (i >= D) chk("stream_out_data", out_data, i - D + 1);
    end
    repeat (3) step(0, 0, 1, acc);
    chk("stream_throughput", n_out - n0, 8);
    // backpressure
    step(1, 8'hA0, 0, acc);
    step(1, 8'hA1, 0, acc);
    step(1, 8'hA2, 0, acc);
    #3;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_occupancy", occupancy, 3);
    chk("bp_out_data", out_data, 8'hA0);
    step(1, 8'hA3, 1, acc);
    chk("bp_push_pop_accept", acc, 1);
    #3;
    chk("bp_occupancy_after", occupancy, 3);
    chk("bp_out_data_after", out_data, 8'hA1);
    repeat (4) step(0, 0, 1, acc);
    // bubble collapse
    step(1, 8'h5A, 0, acc);
    repeat (2) step(0, 0, 0, acc);
    step(1, 8'h5B, 0, acc);
    step(0, 0, 0, acc);
    #3;
    chk("bubble_occupancy", occupancy, 2);
    chk("bubble_out_valid", out_valid, 1);
    chk("bubble_out_data", out_data, 8'h5A);
    // enable freeze then clear
    en = 0;
    repeat (4) begin
      step(1, 8'h66, 1, acc);
      chk("freeze_accept", acc, 0);
      #3;
      chk("freeze_occupancy", occupancy, 2);
      chk("freeze_out_valid", out_valid, 0);
      chk("freeze_in_ready", in_ready, 0);
    end
    en = 1;
    step(0, 0, 0, acc);
    #3;
    chk("thaw_out_valid", out_valid, 1);
    chk("thaw_out_data", out_data, 8'h5A);
    clr = 1;
    step(1, 8'h77, 1, acc);
    chk("clr_accept", acc, 0);
    clr = 0;
    #3;
    chk("clr_occupancy", occupancy, 0);
    chk("clr_out_valid", out_valid, 0);
    repeat (4) step(0, 0, 1, acc);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(7) != 0);
      clr = ($urandom_range(49) == 0);
      step(1'($urandom_range(1)), W'($urandom), $urandom_range(3) != 0, acc);
    end
    clr = 0;
    en = 1;
    repeat (6) step(0, 0, 1, acc);
    chk("drain_occupancy", occupancy, 0);
`ifdef PIPE_REG_CHAIN_PARITY_EN
    step(1, 8'hC3, 0, acc);
    step(1, 8'h07, 0, acc);
    step(1, 8'h81, 0, acc);
    #2;
    chk("parity_clean", parity_err, 0);
    pbad = ~(^out_data);
    force dut.g_stage[D-1].par = pbad;
    #1;
    chk("parity_flip", parity_err, 1);
    release dut.g_stage[D-1].par;
    #1;
    repeat (4) step(0, 0, 1, acc);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
